// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates LSB and instruction-fetch requests onto a byte-serial RAM/IO bus,
// streaming load bytes, assembling little-endian fetch words and sequencing stores.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_signal,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ena_from_lsb,
    input  logic        wr_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [2:0]  len_from_lsb,
    input  logic [31:0] wdata_from_lsb,
    output logic        rdy_2lsb,
    output logic [7:0]  data_2lsb,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, WAIT} state_t;
    state_t      state, state_n;
    logic [31:0] base, base_n, wdata, wdata_n, a_n, fw_n, wsh;
    logic [2:0]  len, len_n, cnt, cnt_n, nxt;
    logic [7:0]  dout_n, d_n;
    logic        wr_r, wr_n, ack_n, done_n;
    assign nxt = cnt + 3'd1;
    assign wsh = wdata >> {nxt, 3'b000};
    // A write only reaches the bus when enabled and, for IO addresses, when the sink has room
    assign mem_wr = wr_r && rdy && !(mem_a >= IO_BASE && io_buffer_full);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            wdata     <= '0;
            cnt       <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            wr_r      <= 1'b0;
            rdy_2lsb  <= 1'b0;
            data_2lsb <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
        end else if (rdy) begin
            state     <= state_n;
            base      <= base_n;
            len       <= len_n;
            wdata     <= wdata_n;
            cnt       <= cnt_n;
            mem_a     <= a_n;
            mem_dout  <= dout_n;
            wr_r      <= wr_n;
            rdy_2lsb  <= ack_n;
            data_2lsb <= d_n;
            if_done   <= done_n;
            if_data   <= fw_n;
        end
    end
    always_comb begin
        state_n = state;
        base_n  = base;
        len_n   = len;
        wdata_n = wdata;
        cnt_n   = cnt;
        a_n     = mem_a;
        dout_n  = mem_dout;
        wr_n    = wr_r;
        ack_n   = 1'b0;
        d_n     = data_2lsb;
        done_n  = 1'b0;
        fw_n    = if_data;
        case (state)
            IDLE: if (!rollback_signal && (ena_from_lsb || if_req)) begin
                base_n  = ena_from_lsb ? addr_from_lsb : if_addr;
                len_n   = ena_from_lsb ? len_from_lsb : 3'd4;
                wdata_n = wdata_from_lsb;
                cnt_n   = '0;
                a_n     = base_n;
                wr_n    = ena_from_lsb && wr_from_lsb;
                dout_n  = wr_n ? wdata_from_lsb[7:0] : mem_dout;
                state_n = !ena_from_lsb ? IF_RD : wr_from_lsb ? LS_WR : LS_RD;
            end
            // cnt counts cycles since accept: byte cnt-1 arrives on mem_din, pulse lands at len+1
            IF_RD, LS_RD: if (rollback_signal) state_n = WAIT;
            else begin
                cnt_n = nxt;
                if (nxt < len) a_n = base + 32'(nxt);
                if (cnt != 3'd0 && cnt <= len) begin
                    if (state == IF_RD) begin
                        fw_n   = {mem_din, if_data[31:8]};
                        done_n = cnt == len;
                    end else begin
                        ack_n = 1'b1;
                        d_n   = mem_din;
                    end
                end
                if (cnt == len + 3'd1) state_n = WAIT;
            end
            LS_WR: if (cnt == len) state_n = WAIT;
            else if (mem_wr) begin
                ack_n = 1'b1;
                cnt_n = nxt;
                if (nxt < len) begin
                    a_n    = base + 32'(nxt);
                    dout_n = wsh[7:0];
                end else wr_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-addressed
// memory image and the request-to-pulse timing rules.
module tb_mem_ctrl;
    logic        clk = 0, rst = 1, rdy = 1, rollback_signal = 0, if_req = 0;
    logic        ena_from_lsb = 0, wr_from_lsb = 0, io_buffer_full = 0;
    logic [31:0] if_addr = 0, addr_from_lsb = 0, wdata_from_lsb = 0;
    logic [2:0]  len_from_lsb = 3'd1;
    logic [7:0]  mem_din = 0;
    logic        if_done, rdy_2lsb, mem_wr;
    logic [31:0] if_data, mem_a;
    logic [7:0]  data_2lsb, mem_dout;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ena_from_lsb(ena_from_lsb), .wr_from_lsb(wr_from_lsb), .addr_from_lsb(addr_from_lsb),
        .len_from_lsb(len_from_lsb), .wdata_from_lsb(wdata_from_lsb),
        .rdy_2lsb(rdy_2lsb), .data_2lsb(data_2lsb), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int compared = 0, mism = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ram is the physical memory the DUT talks to; mirror is the expected memory image
    logic [7:0] ram [logic [31:0]];
    logic [7:0] mirror [logic [31:0]];
    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction
    function automatic logic [7:0] mrd(input logic [31:0] a);
        return mirror.exists(a) ? mirror[a] : 8'h00;
    endfunction
    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        mirror[a] = b;
    endtask

    always @(posedge clk) begin
        mem_din <= rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    int rc[$], dc[$], wc[$];
    logic [7:0] rq[$], wq[$];
    logic [31:0] dq[$], wa[$];
    always @(negedge clk) if (rst) begin
        if (rdy_2lsb) begin rc.push_back(cyc); rq.push_back(data_2lsb); end
        if (if_done) begin dc.push_back(cyc); dq.push_back(if_data); end
        if (mem_wr) begin wc.push_back(cyc); wa.push_back(mem_a); wq.push_back(mem_dout); end
    end

    task automatic clear_q();
        rc.delete(); rq.delete(); dc.delete(); dq.delete(); wc.delete(); wa.delete(); wq.delete();
    endtask

    // kind: 0 load, 1 store, 2 fetch; rb_at/pause_at are cycle offsets from accept (-1 = none)
    task automatic txn(input int kind, input logic [31:0] a, input logic [2:0] n, input logic [31:0] wd,
                       input int rb_at, input int full_cyc, input int pause_at, input string tag);
        int t, rel, sh, en;
        bit fin;
        logic [31:0] w;
        clear_q();
        @(posedge clk); #1;
        t = cyc;
        if (kind == 2) begin if_req = 1; if_addr = a; end
        else begin
            ena_from_lsb = 1; wr_from_lsb = (kind == 1); addr_from_lsb = a;
            len_from_lsb = n; wdata_from_lsb = wd;
        end
        fin = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            rel = cyc - t;
            rollback_signal = (rel == rb_at);
            io_buffer_full = rel >= 1 && rel <= full_cyc;
            rdy = rel != pause_at;
            if (rel == rb_at + 1 || (kind == 2 ? dc.size() > 0 : rc.size() >= int'(n))) begin
                fin = 1; if_req = 0; ena_from_lsb = 0; rollback_signal = 0;
            end
        end
        compared++;
        if (!fin) begin
            $display("FAIL %s timeout got no completion want completion within 40 cycles", tag);
            mism++;
            if_req = 0; ena_from_lsb = 0; rollback_signal = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        io_buffer_full = 0; rdy = 1;
        sh = (full_cyc > 0 ? full_cyc : 0) + (pause_at > 0 ? 1 : 0);
        if (kind == 0) begin
            en = rb_at > 0 ? 0 : int'(n);
            compared++;
            if (rc.size() != en) begin
                $display("FAIL %s load_pulses got %0d want %0d", tag, rc.size(), en); mism++;
            end
            for (int k = 0; k < en && k < rc.size(); k++) begin
                compared += 2;
                if (rc[k] != t + 3 + k) begin
                    $display("FAIL %s load_cycle[%0d] got %0d want %0d", tag, k, rc[k] - t, 3 + k); mism++;
                end
                if (rq[k] !== mrd(a + 32'(k))) begin
                    $display("FAIL %s load_byte[%0d] got %h want %h", tag, k, rq[k], mrd(a + 32'(k))); mism++;
                end
            end
        end else if (kind == 1) begin
            compared += 2;
            if (wc.size() != int'(n)) begin
                $display("FAIL %s write_count got %0d want %0d", tag, wc.size(), n); mism++;
            end
            if (rc.size() != int'(n)) begin
                $display("FAIL %s store_pulses got %0d want %0d", tag, rc.size(), n); mism++;
            end
            for (int k = 0; k < int'(n); k++) begin
                if (k < wc.size()) begin
                    compared += 3;
                    if (wc[k] != t + 1 + sh + k) begin
                        $display("FAIL %s write_cycle[%0d] got %0d want %0d", tag, k, wc[k] - t, 1 + sh + k); mism++;
                    end
                    if (wa[k] !== a + 32'(k)) begin
                        $display("FAIL %s write_addr[%0d] got %h want %h", tag, k, wa[k], a + 32'(k)); mism++;
                    end
                    if (wq[k] !== wd[8*k +: 8]) begin
                        $display("FAIL %s write_data[%0d] got %h want %h", tag, k, wq[k], wd[8*k +: 8]); mism++;
                    end
                end
                if (k < rc.size()) begin
                    compared++;
                    if (rc[k] != t + 2 + sh + k) begin
                        $display("FAIL %s store_pulse_cycle[%0d] got %0d want %0d", tag, k, rc[k] - t, 2 + sh + k); mism++;
                    end
                end
                mirror[a + 32'(k)] = wd[8*k +: 8];
            end
        end else begin
            en = rb_at > 0 ? 0 : 1;
            w = {mrd(a + 3), mrd(a + 2), mrd(a + 1), mrd(a)};
            compared++;
            if (dc.size() != en) begin
                $display("FAIL %s fetch_pulses got %0d want %0d", tag, dc.size(), en); mism++;
            end
            if (en == 1 && dc.size() > 0) begin
                compared += 2;
                if (dc[0] != t + 6) begin
                    $display("FAIL %s fetch_cycle got %0d want 6", tag, dc[0] - t); mism++;
                end
                if (dq[0] !== w) begin
                    $display("FAIL %s fetch_word got %h want %h", tag, dq[0], w); mism++;
                end
            end
        end
        if (kind != 1) begin
            compared++;
            if (wc.size() != 0) begin
                $display("FAIL %s stray_writes got %0d want 0", tag, wc.size()); mism++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        int t;
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        outs = {mem_a[15:0], mem_dout, 5'd0, mem_wr, rdy_2lsb, if_done};
        compared += 4;
        if (outs !== 32'h0) begin $display("FAIL reset_ctrl got %h want 0", outs); mism++; end
        if (mem_a !== 32'h0) begin $display("FAIL reset_mem_a got %h want 0", mem_a); mism++; end
        if (data_2lsb !== 8'h0) begin $display("FAIL reset_data_2lsb got %h want 0", data_2lsb); mism++; end
        if (if_data !== 32'h0) begin $display("FAIL reset_if_data got %h want 0", if_data); mism++; end
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({mem_wr, rdy_2lsb, if_done} !== 3'b000) begin
            $display("FAIL idle_after_reset got %b want 000", {mem_wr, rdy_2lsb, if_done}); mism++;
        end
        // assert reset in the middle of a store: nothing may be written
        ena_from_lsb = 1; wr_from_lsb = 1; addr_from_lsb = 32'h500; len_from_lsb = 3'd4;
        wdata_from_lsb = 32'h1234_5678;
        t = cyc;
        @(posedge clk); #1;
        compared++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h500) begin
            $display("FAIL midreset_precond got wr=%b a=%h want wr=1 a=500", mem_wr, mem_a); mism++;
        end
        #2 rst = 0;
        #1;
        compared += 2;
        if (mem_wr !== 1'b0) begin $display("FAIL midreset_wr got %b want 0", mem_wr); mism++; end
        if (mem_a !== 32'h0) begin $display("FAIL midreset_a got %h want 0", mem_a); mism++; end
        ena_from_lsb = 0;
        @(posedge clk); #1;
        rst = 1;
        repeat (6) @(posedge clk);
        #1;
        compared++;
        if (rd(32'h500) !== 8'h00) begin $display("FAIL midreset_ram got %h want 00", rd(32'h500)); mism++; end
    endtask

    task automatic test_load();
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        txn(0, 32'h100, 3'd4, 0, -1, 0, -1, "lw_0x100");
        txn(0, 32'h102, 3'd2, 0, -1, 0, -1, "lh_0x102");
        txn(0, 32'h101, 3'd1, 0, -1, 0, -1, "lb_0x101");
    endtask

    task automatic test_fetch();
        poke(32'h0, 8'h13); poke(32'h1, 8'h05); poke(32'h2, 8'h00); poke(32'h3, 8'h00);
        txn(2, 32'h0, 3'd4, 0, -1, 0, -1, "fetch_0x0");
    endtask

    task automatic test_store();
        txn(1, 32'h200, 3'd4, 32'hDEAD_BEEF, -1, 0, -1, "sw_0x200");
        txn(0, 32'h200, 3'd4, 0, -1, 0, -1, "lw_back_0x200");
        txn(1, 32'h400, 3'd1, 32'h0000_00A5, -1, 0, 1, "sb_paused");
        txn(0, 32'h400, 3'd1, 0, -1, 0, -1, "lb_back_0x400");
    endtask

    task automatic test_io_stall();
        txn(1, 32'h0003_0000, 3'd1, 32'h0000_0041, -1, 3, -1, "sb_io_stall");
    endtask

    task automatic test_rollback();
        poke(32'h300, 8'h5A); poke(32'h301, 8'hC3);
        txn(0, 32'h300, 3'd2, 0, 1, 0, -1, "lh_rollback");
        txn(1, 32'h310, 3'd2, 32'h0000_BEAD, 1, 0, -1, "sh_rollback");
        txn(0, 32'h310, 3'd2, 0, -1, 0, -1, "lh_back_0x310");
    endtask

    task automatic test_priority();
        int t, p;
        logic [31:0] w;
        bit fin;
        for (int i = 0; i < 4; i++) begin poke(32'h600 + i, 8'(8'hA0 + i)); poke(32'h700 + i, 8'(8'hB0 + i)); end
        clear_q();
        @(posedge clk); #1;
        t = cyc;
        ena_from_lsb = 1; wr_from_lsb = 0; addr_from_lsb = 32'h600; len_from_lsb = 3'd4;
        if_req = 1; if_addr = 32'h700;
        fin = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(posedge clk); #1;
            if (rc.size() >= 4) ena_from_lsb = 0;
            if (dc.size() > 0) begin if_req = 0; fin = 1; end
        end
        ena_from_lsb = 0; if_req = 0;
        repeat (4) @(posedge clk);
        compared += 3;
        if (rc.size() != 4) begin $display("FAIL prio_lsb_pulses got %0d want 4", rc.size()); mism++; end
        if (dc.size() != 1) begin $display("FAIL prio_fetch_pulses got %0d want 1", dc.size()); mism++; end
        if (rc.size() > 0 && rc[0] != t + 3) begin
            $display("FAIL prio_lsb_first got %0d want 3", rc[0] - t); mism++;
        end
        for (int k = 0; k < rc.size() && k < 4; k++) begin
            compared++;
            if (rq[k] !== mrd(32'h600 + k)) begin
                $display("FAIL prio_lsb_byte[%0d] got %h want %h", k, rq[k], mrd(32'h600 + k)); mism++;
            end
        end
        if (rc.size() == 4 && dc.size() == 1) begin
            p = rc[3];
            w = {mrd(32'h703), mrd(32'h702), mrd(32'h701), mrd(32'h700)};
            compared += 2;
            if (dc[0] != p + 8) begin $display("FAIL prio_fetch_cycle got %0d want %0d", dc[0] - p, 8); mism++; end
            if (dq[0] !== w) begin $display("FAIL prio_fetch_word got %h want %h", dq[0], w); mism++; end
        end
    endtask

    task automatic test_random();
        int kind;
        logic [2:0] n;
        logic [31:0] a;
        for (int i = 0; i < 260; i++) poke(32'h1000 + i, 8'($urandom));
        poke(32'hFFFF_FFFE, 8'($urandom)); poke(32'hFFFF_FFFF, 8'($urandom));
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            n = kind == 2 ? 3'd4 : 3'(1 << $urandom_range(0, 2));
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'h1000 + $urandom_range(0, 255);
            txn(kind, a, n, $urandom, -1, 0, -1, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_store();
        test_io_stall();
        test_rollback();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
